// File: rtl/mcp01_pkg.sv
// Shared constants for the mcp01 ALU stage: data/address widths and ALU opcodes.
package mcp01_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

endpackage

// File: rtl/mcp01_mux2.sv
// Generic 2:1 multiplexer used for the operand A, operand B and next-PC selects.
module mcp01_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mcp01_alu_stage.sv
// ALU stage: operand muxes, 4-op ALU, next-PC mux and ALU output register.
// Optional registered zero/carry flags are built when MCP01_ALU_FLAGS_EN is defined.
module mcp01_alu_stage
  import mcp01_pkg::*;
#(
  parameter logic [DATA_W-1:0] INC_CONST = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] ir_addr,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              alu_src_a,
  input  logic              alu_src_b,
  input  logic [1:0]        alu_control,
  input  logic              pc_sel,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_out,
  output logic [ADDR_W-1:0] pc_next
`ifdef MCP01_ALU_FLAGS_EN
  ,
  output logic              zero,
  output logic              carry
`endif
);

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] alu_out_d;
  logic [DATA_W-1:0] alu_out_q;

  assign pc_ext = {{(DATA_W-ADDR_W){1'b0}}, pc};

  mcp01_mux2 #(.WIDTH(DATA_W)) u_mux_a (
    .sel (alu_src_a),
    .in0 (pc_ext),
    .in1 (op1),
    .y   (opnd_a)
  );

  mcp01_mux2 #(.WIDTH(DATA_W)) u_mux_b (
    .sel (alu_src_b),
    .in0 (INC_CONST),
    .in1 (op2),
    .y   (opnd_b)
  );

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = opnd_a + opnd_b;
      ALU_SUB: alu_result = opnd_a - opnd_b;
      ALU_AND: alu_result = opnd_a & opnd_b;
      default: alu_result = ~opnd_a;
    endcase
  end

  // Upper result bits are dropped, so the PC wraps modulo 32.
  mcp01_mux2 #(.WIDTH(ADDR_W)) u_mux_pc (
    .sel (pc_sel),
    .in0 (alu_result[ADDR_W-1:0]),
    .in1 (ir_addr),
    .y   (pc_next)
  );

  always_comb begin
    alu_out_d = alu_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out_q <= '0;
    end else begin
      alu_out_q <= alu_out_d;
    end
  end

  assign alu_out = alu_out_q;

`ifdef MCP01_ALU_FLAGS_EN
  logic [DATA_W:0] add_wide;
  logic            zero_d;
  logic            carry_d;
  logic            zero_q;
  logic            carry_q;

  assign add_wide = {1'b0, opnd_a} + {1'b0, opnd_b};

  // Carry means carry-out on ADD and unsigned borrow on SUB.
  always_comb begin
    zero_d  = (alu_result == '0);
    carry_d = 1'b0;
    case (alu_control)
      ALU_ADD: carry_d = add_wide[DATA_W];
      ALU_SUB: carry_d = (opnd_a < opnd_b);
      default: carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;
`endif

endmodule

// File: tb/tb_mcp01_alu_stage.sv
// Self-checking bench for mcp01_alu_stage: directed cases plus randomized
// stimulus against an arithmetic reference model. Flag checks follow MCP01_ALU_FLAGS_EN.
module tb_mcp01_alu_stage;

  logic       clk;
  logic       rst;
  logic [4:0] pc;
  logic [4:0] ir_addr;
  logic [7:0] op1;
  logic [7:0] op2;
  logic       alu_src_a;
  logic       alu_src_b;
  logic [1:0] alu_control;
  logic       pc_sel;
  logic [7:0] alu_result;
  logic [7:0] alu_out;
  logic [4:0] pc_next;
`ifdef MCP01_ALU_FLAGS_EN
  logic       zero;
  logic       carry;
`endif

  int tests_run;
  int tests_failed;

  mcp01_alu_stage #(.INC_CONST(8'h01)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .ir_addr     (ir_addr),
    .op1         (op1),
    .op2         (op2),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .pc_sel      (pc_sel),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .pc_next     (pc_next)
`ifdef MCP01_ALU_FLAGS_EN
    ,
    .zero        (zero),
    .carry       (carry)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic from the operation definitions.
  function automatic int model_a(input logic sa, input logic [4:0] p, input logic [7:0] o1);
    return sa ? int'(o1) : int'(p);
  endfunction

  function automatic int model_b(input logic sb, input logic [7:0] o2);
    return sb ? int'(o2) : 1;
  endfunction

  function automatic logic [7:0] model_result(input int a, input int b, input logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = (a + b) % 256;
      2'd1:    r = (a - b + 256) % 256;
      2'd2:    r = a & b;
      default: r = 255 - a;
    endcase
    return 8'(r);
  endfunction

  function automatic logic model_carry(input int a, input int b, input logic [1:0] op);
    if (op == 2'd0) return (a + b) > 255;
    if (op == 2'd1) return a < b;
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic sa, input logic sb, input logic [1:0] op,
                               input logic ps, input logic [4:0] p, input logic [4:0] ir,
                               input logic [7:0] o1, input logic [7:0] o2);
    @(negedge clk);
    alu_src_a   = sa;
    alu_src_b   = sb;
    alu_control = op;
    pc_sel      = ps;
    pc          = p;
    ir_addr     = ir;
    op1         = o1;
    op2         = o2;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Applies one vector, checks combinational outputs, then the registered ones after an edge.
  task automatic runVector(input string tag, input logic sa, input logic sb, input logic [1:0] op,
                           input logic ps, input logic [4:0] p, input logic [4:0] ir,
                           input logic [7:0] o1, input logic [7:0] o2);
    int a;
    int b;
    logic [7:0] er;
    logic [4:0] ep;
    a  = model_a(sa, p, o1);
    b  = model_b(sb, o2);
    er = model_result(a, b, op);
    ep = ps ? ir : 5'(er % 32);
    applyStimulus(sa, sb, op, ps, p, ir, o1, o2);
    checkOutput({tag, "_result"}, alu_result, er);
    checkOutput({tag, "_pc_next"}, {3'b000, pc_next}, {3'b000, ep});
    @(posedge clk);
    #1;
    checkOutput({tag, "_alu_out"}, alu_out, er);
`ifdef MCP01_ALU_FLAGS_EN
    checkOutput({tag, "_zero"}, {7'd0, zero}, {7'd0, (er == 8'h00)});
    checkOutput({tag, "_carry"}, {7'd0, carry}, {7'd0, model_carry(a, b, op)});
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_control  = 2'b00;
    pc_sel       = 1'b0;
    pc           = 5'h00;
    ir_addr      = 5'h00;
    op1          = 8'h00;
    op2          = 8'h00;

    #2;
    checkOutput("reset_alu_out", alu_out, 8'h00);
`ifdef MCP01_ALU_FLAGS_EN
    checkOutput("reset_zero", {7'd0, zero}, 8'h00);
    checkOutput("reset_carry", {7'd0, carry}, 8'h00);
`endif
    @(posedge clk);
    #1;
    checkOutput("reset_held_edge", alu_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    runVector("pc_inc",   1'b0, 1'b0, 2'b00, 1'b0, 5'h07, 5'h00, 8'h00, 8'h00);
    runVector("pc_wrap",  1'b0, 1'b0, 2'b00, 1'b0, 5'h1F, 5'h00, 8'h00, 8'h00);
    runVector("sub_wrap", 1'b1, 1'b1, 2'b01, 1'b0, 5'h00, 5'h00, 8'h05, 8'h07);
    runVector("and",      1'b1, 1'b1, 2'b10, 1'b0, 5'h00, 5'h00, 8'hF0, 8'h3C);
    runVector("not_ff",   1'b1, 1'b1, 2'b11, 1'b0, 5'h00, 5'h00, 8'hFF, 8'h12);
    runVector("add_carry",1'b1, 1'b1, 2'b00, 1'b0, 5'h00, 5'h00, 8'hFF, 8'h01);
    runVector("sub_0_1",  1'b1, 1'b1, 2'b01, 1'b0, 5'h00, 5'h00, 8'h00, 8'h01);
    runVector("jump",     1'b1, 1'b1, 2'b00, 1'b1, 5'h03, 5'h15, 8'h44, 8'h22);
    runVector("mix_b",    1'b1, 1'b0, 2'b00, 1'b0, 5'h09, 5'h00, 8'h7F, 8'h99);

    checkOutput("fixed_pc_inc_value", model_result(7, 1, 2'b00), 8'h08);

    for (int i = 0; i < 60; i++) begin
      runVector("rand", 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
    end

    // Asynchronous reset assertion in the middle of a cycle.
    runVector("preload_ab", 1'b1, 1'b1, 2'b10, 1'b0, 5'h00, 5'h00, 8'hAB, 8'hFF);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_clear", alu_out, 8'h00);
    checkOutput("comb_in_reset", alu_result, 8'hAB);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_in_reset", alu_out, 8'h00);
`ifdef MCP01_ALU_FLAGS_EN
    checkOutput("held_zero", {7'd0, zero}, 8'h00);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("release_waits_edge", alu_out, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("release_load", alu_out, 8'hAB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
